// File: rtl/controle_divisor_8bits.sv
// Restoring 8-bit divider sequencing one ripple subtractor over ITER cycles; done pulses 9 cycles after start (1 on B==0).
// Optional DIV_SIGNED_EN: two's-complement operands with a sign-correction state (latency 10); start is ignored while busy.
module controle_divisor_8bits #(
    parameter int ITER = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       busy,
    output logic       done,
    output logic       div_zero
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {OCIOSO = 2'd0, ITERA = 2'd1, CORRIGE = 2'd2, FIM = 2'd3} state_t;
`else
    typedef enum logic [1:0] {OCIOSO = 2'd0, ITERA = 2'd1, FIM = 2'd3} state_t;
`endif

    state_t     state;
    logic [7:0] dvd;        // dividend shifting out, quotient bits shifting in
    logic [7:0] dvs;
    logic [7:0] part_rem;
    logic [2:0] count;
    logic       zero_flag;
`ifdef DIV_SIGNED_EN
    logic       sign_q;
    logic       sign_r;
    logic [7:0] a_mag;
    logic [7:0] b_mag;
`endif

    logic [8:0] p_shift;
    logic [7:0] diff;
    logic       borrow;
    logic       accept;
    logic [7:0] r_next;

    // One iteration: shift in the next dividend bit, trial-subtract on the 8-bit ripple subtractor.
    always_comb begin
        p_shift = {part_rem, dvd[7]};
        diff    = 8'h00;
        borrow  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            diff[i] = p_shift[i] ^ dvs[i] ^ borrow;
            borrow  = (~p_shift[i] & dvs[i]) | (~(p_shift[i] ^ dvs[i]) & borrow);
        end
        // A carried-out 9th bit means the shifted remainder exceeds any 8-bit divisor.
        accept = p_shift[8] | ~borrow;
        r_next = accept ? diff : p_shift[7:0];
    end

`ifdef DIV_SIGNED_EN
    always_comb begin
        a_mag = A[7] ? (~A + 8'd1) : A;
        b_mag = B[7] ? (~B + 8'd1) : B;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OCIOSO;
            Q         <= 8'h00;
            R         <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            dvd       <= 8'h00;
            dvs       <= 8'h00;
            part_rem  <= 8'h00;
            count     <= 3'd0;
            zero_flag <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
`endif
        end else begin
            case (state)
                OCIOSO: begin
                    done <= 1'b0;
                    // The cycle that shows done still belongs to the finished division.
                    if (start && !done) begin
                        busy      <= 1'b1;
                        part_rem  <= 8'h00;
                        count     <= 3'd0;
                        zero_flag <= (B == 8'h00);
`ifdef DIV_SIGNED_EN
                        dvd       <= (B == 8'h00) ? A : a_mag;
                        dvs       <= b_mag;
                        sign_q    <= A[7] ^ B[7];
                        sign_r    <= A[7];
`else
                        dvd       <= A;
                        dvs       <= B;
`endif
                        state     <= (B == 8'h00) ? FIM : ITERA;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ITERA: begin
                    dvd      <= {dvd[6:0], accept};
                    part_rem <= r_next;
                    count    <= count + 3'd1;
                    if (count == 3'(ITER - 1)) begin
`ifdef DIV_SIGNED_EN
                        state <= CORRIGE;
`else
                        state <= FIM;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                CORRIGE: begin
                    if (sign_q) dvd <= ~dvd + 8'd1;
                    if (sign_r) part_rem <= ~part_rem + 8'd1;
                    state <= FIM;
                end
`endif
                FIM: begin
                    done     <= 1'b1;
                    busy     <= 1'b1;
                    Q        <= zero_flag ? 8'hFF : dvd;
                    R        <= zero_flag ? dvd : part_rem;
                    div_zero <= zero_flag;
                    state    <= OCIOSO;
                end
                default: state <= OCIOSO;
            endcase
        end
    end

endmodule
